// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// FSM state codes, opcode/funct values, ALU operations and mux selects.
package mc_ctrl_pkg;

  localparam logic [3:0] RST_S    = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] MEM_ADDR = 4'd3;
  localparam logic [3:0] MEM_RD   = 4'd4;
  localparam logic [3:0] MEM_WB   = 4'd5;
  localparam logic [3:0] MEM_WR   = 4'd6;
  localparam logic [3:0] R_EXEC   = 4'd7;
  localparam logic [3:0] R_WB     = 4'd8;
  localparam logic [3:0] I_EXEC   = 4'd9;
  localparam logic [3:0] I_WB     = 4'd10;
  localparam logic [3:0] BRANCH   = 4'd11;
  localparam logic [3:0] JUMP     = 4'd12;
  localparam logic [3:0] TRAP     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_OR_ZX = 4'd8;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-operation decode from opcode/funct, flagging
// unsupported R-type funct codes so the FSM can trap on them.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_funct_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      OP_SLTI: alu_ctrl_o = ALU_SLT;
      OP_ORI:  alu_ctrl_o = ALU_OR_ZX;
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with Moore output decode.
// Define MC_CTRL_JUMP_EN to decode opcode 2 (j) into the JUMP state.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_ctrl_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  logic [3:0] state_q, state_d;
  logic       arm_q, arm_d;
  logic [3:0] dec_alu_ctrl;
  logic       dec_illegal_funct;

  mc_alu_decode u_alu_decode (
    .opcode_i        (opcode_i),
    .funct_i         (funct_i),
    .alu_ctrl_o      (dec_alu_ctrl),
    .illegal_funct_o (dec_illegal_funct)
  );

  // arm_q holds RST_S for one extra edge after reset release
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RST_S;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = 1'b1;
    case (state_q)
      RST_S:    if (arm_q) state_d = FETCH;
      FETCH:    if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_RTYPE:                 state_d = R_EXEC;
          OP_ADDI, OP_SLTI, OP_ORI: state_d = I_EXEC;
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:                     state_d = JUMP;
`endif
          default:                  state_d = TRAP;
        endcase
      end
      MEM_ADDR: state_d = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready_i) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready_i) state_d = FETCH;
      R_EXEC:   state_d = dec_illegal_funct ? TRAP : R_WB;
      R_WB:     state_d = FETCH;
      I_EXEC:   state_d = I_WB;
      I_WB:     state_d = FETCH;
      BRANCH:   state_d = FETCH;
`ifdef MC_CTRL_JUMP_EN
      JUMP:     state_d = FETCH;
`endif
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
  end

  // Outputs depend on state only, except the FETCH/BRANCH write strobes
  always_comb begin
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PCSRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu_ctrl_o   = ALU_AND;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_ctrl_o  = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        alu_ctrl_o  = ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_ctrl_o  = ALU_ADD;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o  = dec_alu_ctrl;
      end
      R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_ctrl_o  = dec_alu_ctrl;
      end
      I_WB:     reg_write_o = 1'b1;
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o  = ALU_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        pc_src_o   = PCSRC_JUMP;
        pc_write_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign illegal_o = (state_q == TRAP);

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Control FSM that sequences a multi-cycle MIPS-subset datapath: one shared memory port for instruction and data, one ALU reused for PC+4, branch target and execution. Decodes opcode/funct from the instruction register and drives every mux select, write enable and ALU operation each cycle. It replaces the single-cycle decoder/ALU-control pair when the CPU moves to the multi-cycle datapath.

## Interface
- No parameters.
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- opcode_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU zero flag, valid in BRANCH state
- mem_ready_i  in  1  memory completes current access this cycle
- mem_read_o / mem_write_o  out  1  memory strobes
- iord_o  out  1  0 = address from PC, 1 = from ALUOut
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC (unconditional or qualified branch)
- pc_src_o  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target
- alu_src_a_o  out  1  0 = PC, 1 = RS
- alu_src_b_o  out  2  0 = RT, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_ctrl_o  out  4  ALU operation (package encoding)
- reg_dst_o  out  1  0 = rt, 1 = rd
- mem_to_reg_o  out  1  0 = ALUOut, 1 = MDR
- reg_write_o  out  1  register-file write enable
- state_o  out  4  current state, debug
- illegal_o  out  1  sticky illegal-opcode flag

## Operation
- States: RST_S, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- RST_S: all outputs 0; next FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_src=0. Hold while mem_ready_i=0; when 1: ir_write=1, pc_write=1, next DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=ADD (branch target into ALUOut). Next: op 0 -> R_EXEC; 8/10/13 -> I_EXEC; 35/43 -> MEM_ADDR; 4/5 -> BRANCH; 2 -> JUMP (macro only); else TRAP.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctrl from funct (add 32, sub 34, and 36, or 37, slt 42; other funct -> TRAP). Next R_WB: reg_dst=1, reg_write=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_ctrl ADD (addi), SLT (slti), OR_ZX (ori, zero-extended imm). Next I_WB: reg_dst=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, iord=1; wait mem_ready_i; then MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; wait mem_ready_i -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_write = zero_i for beq, ~zero_i for bne -> FETCH.
- JUMP: pc_src=2, pc_write=1 -> FETCH.
- TRAP: all strobes 0, illegal_o=1, absorbing until reset.

## Timing
- Zero-wait-state cycles per instruction: R 4, addi/slti/ori 4, lw 5, sw 4, beq/bne 3, j 3; each mem_ready_i=0 cycle adds one.
- Outputs are Moore decodes of state, except ir_write_o/pc_write_o in FETCH (gated by mem_ready_i) and pc_write_o in BRANCH (gated by zero_i): same-cycle combinational.
- mem_read_o/mem_write_o stay high, address select stable, for the full wait; never both high.
- Reset asserted mid-instruction: immediately RST_S, all outputs 0, illegal_o cleared; first FETCH on the second edge after deassertion.

## Configuration
- MC_CTRL_JUMP_EN defined: opcode 2 decodes to JUMP, pc_src=2 reachable.
- Undefined: opcode 2 goes to TRAP; pc_src_o never 2; JUMP state not built.

## Structure
- Package mc_ctrl_pkg: state enum (4-bit), opcode and funct constants, ALU control encoding (AND 0, OR 1, ADD 2, SUB 6, SLT 7, OR_ZX 8), alu_src_b and pc_src encodings.
- One sub-module: mc_alu_decode (combinational funct/opcode -> alu_ctrl, illegal-funct flag); FSM and output decode stay in multi_cycle_ctrl.

## Test plan
- Reset low 3 cycles, release, mem_ready_i=1: state_o RST_S -> FETCH, all strobes 0 during reset, ir_write_o=pc_write_o=1 in first FETCH cycle.
- add (op 0, funct 32), ready=1: FETCH, DECODE, R_EXEC alu_ctrl=2, R_WB reg_dst=1 reg_write=1; back to FETCH after exactly 4 cycles.
- lw (op 35), 2 wait cycles in FETCH and MEM_RD: mem_read_o held 3 cycles each, iord 0 then 1; MEM_WB mem_to_reg=1; total 9 cycles.
- beq with zero_i=1 -> pc_write_o=1, pc_src_o=1; bne with zero_i=1 -> pc_write_o=0; each 3 cycles.
- Opcode 63 (and R funct 0): TRAP, illegal_o=1, no strobes for 20 cycles; reset clears illegal_o.
- Opcode 2 with/without MC_CTRL_JUMP_EN: JUMP pc_src=2 pc_write=1, 3 cycles / TRAP, illegal_o=1.
